// File: rtl/ripple_carry_counter.sv
// Ripple-carry binary up-counter.
// WIDTH toggle stages (legal range 1..32) are chained so that each stage is
// clocked by the falling edge of the stage below it. Stage 0 is clocked by the
// falling edge of clk. The active-low rst clears every stage asynchronously.
// While rst is low every stage is held in clear. Falling edges of q caused by
// that clear therefore cannot toggle any downstream stage.

// D flip-flop: captures on the falling clock edge, asynchronous active-low clear.
module rcc_dff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_q;

   // Capture D on the falling edge; clear immediately whenever reset is low
   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= 1'b0;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// T flip-flop with T tied high: a D flip-flop fed by its own inverted output.
module rcc_tff (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_q
);

   logic w_q;
   logic w_d;

   assign w_d = ~w_q;

   rcc_dff u_dff (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (w_d),
      .o_q     (w_q)
   );

   assign o_q = w_q;

endmodule

// Counter top: stage 0 runs from clk, and stage g runs from q[g-1].
module ripple_carry_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] w_q;

   for (genvar g = 0; g < WIDTH; g++) begin : g_stage
      if (g == 0) begin : g_lsb
         rcc_tff u_tff (
            .i_clk   (clk),
            .i_rst_n (rst),
            .o_q     (w_q[g])
         );
      end else begin : g_upper
         // A 1->0 transition of the lower stage is the carry into this stage
         rcc_tff u_tff (
            .i_clk   (w_q[g-1]),
            .i_rst_n (rst),
            .o_q     (w_q[g])
         );
      end
   end

   assign q = w_q;

endmodule

// File: tb/tb_ripple_carry_counter.sv
// Self-checking bench for ripple_carry_counter (4-bit and 8-bit instances).
module tb_ripple_carry_counter;

   logic       clk;
   logic       rst4;
   logic       rst8;
   logic [3:0] q4;
   logic [7:0] q8;

   int n_tests;
   int n_fail;
   bit valid;

   // Reference counts: plain modular arithmetic on the falling clk edge
   int m4;
   int m8;

   ripple_carry_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .q(q4));
   ripple_carry_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .q(q8));

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // 4-bit model: clear on reset, otherwise add one modulo 16 on each falling clk edge
   always @(negedge clk or negedge rst4) begin
      if (!rst4) m4 <= 0;
      else       m4 <= (m4 + 1) % 16;
   end

   // 8-bit model: clear on reset, otherwise add one modulo 256 on each falling clk edge
   always @(negedge clk or negedge rst8) begin
      if (!rst8) m8 <= 0;
      else       m8 <= (m8 + 1) % 256;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, taken 4 units after each clk edge
   always @(clk) begin
      if (valid) begin
         #4;
         chk("model_q4", int'(q4), m4);
         chk("model_q8", int'(q8), m8);
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      valid   = 1'b0;
      m4      = 0;
      m8      = 0;
      rst4    = 1'b1;
      rst8    = 1'b1;
      #1;
      rst4 = 1'b0;
      rst8 = 1'b0;
      #1;
      valid = 1'b1;
      chk("reset_immediate", int'(q4), 0);

      // Hold reset for 50 time units while clk toggles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #3;
         chk("reset_hold", int'(q4), 0);
      end

      // Release between edges (clk low), then count 16 falling edges including the wrap
      @(negedge clk); #2;
      rst4 = 1'b1;
      #1;
      chk("release_hold", int'(q4), 0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk); #3;
         chk("count_wrap", int'(q4), i % 16);
      end
      chk("wrap_zero", int'(q4), 0);

      // Count to 5, then assert reset between edges
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #3;
      end
      chk("count_to_5", int'(q4), 5);
      #1;
      rst4 = 1'b0;
      #1;
      chk("abort_mid_count", int'(q4), 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #3;
         chk("abort_hold", int'(q4), 0);
      end

      // Release while clk is high: q stays 0 until the following falling edge
      @(posedge clk); #2;
      rst4 = 1'b1;
      #1;
      chk("release_clk_high", int'(q4), 0);
      @(negedge clk); #3;
      chk("first_after_release", int'(q4), 1);
      @(posedge clk); #3;
      chk("rise_no_change", int'(q4), 1);

      // Toggle reset every 30 time units, starting with rst high
      rst4 = 1'b0;
      @(posedge clk); #2;
      for (int w = 0; w < 3; w++) begin
         rst4 = 1'b1;
         #6;  chk("window_1", int'(q4), 1);
         #10; chk("window_2", int'(q4), 2);
         #10; chk("window_3", int'(q4), 3);
         #4;
         rst4 = 1'b0;
         #1;  chk("window_low", int'(q4), 0);
         #19; chk("window_low_hold", int'(q4), 0);
         #10;
      end

      // 8-bit instance: 256 falling edges, checking the full-carry step and the wrap
      @(negedge clk); #2;
      rst8 = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk); #3;
         if (i == 127) chk("w8_7f", int'(q8), 8'h7F);
         if (i == 128) chk("w8_80", int'(q8), 8'h80);
      end
      chk("w8_wrap", int'(q8), 0);

      @(negedge clk); #6;
      valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
